// File: rtl/bram_save_scheduler.sv
// Schedules round-robin channel writes into a shared single-port BRAM during a save pass
// and serves user reads from the same port outside a save pass.
module bram_save_scheduler #(
    parameter int unsigned NCH = 8,
    parameter int unsigned AW  = 18,
    parameter int unsigned DW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              saving_mode,
    input  logic [NCH*AW-1:0] starting_addr,
    input  logic [AW-1:0]     ch_len,
    input  logic [NCH-1:0]    ch_valid,
    input  logic [NCH*DW-1:0] ch_data,
    output logic [NCH-1:0]    ch_ready,
    input  logic              user_rd_en,
    input  logic [AW-1:0]     user_addr,
    output logic              user_rd_valid,
    output logic [DW-1:0]     user_rd_data,
    output logic              bram_en,
    output logic              bram_we,
    output logic [AW-1:0]     bram_addr,
    output logic [DW-1:0]     bram_wdata,
    input  logic [DW-1:0]     bram_rdata,
    output logic [NCH-1:0]    ch_done,
    output logic              all_done
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {StIdle, StSave, StDone} state_e;

    state_e          state;
    logic [AW-1:0]   addr_cnt [NCH];
    logic [AW-1:0]   word_cnt [NCH];
    logic [AW-1:0]   len_q;
    logic [PW-1:0]   rr_ptr;
    logic            rd_pend;

    logic [NCH-1:0]  eligible;
    logic [NCH-1:0]  done_d;
    logic [PW-1:0]   idx;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_found;
    logic            rd_issue;

    // A channel that already reached its length is never granted, even before ch_done rises.
    always_comb begin
        eligible  = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = rr_ptr;
        ch_ready  = '0;
        for (int i = 0; i < NCH; i++) begin
            eligible[i] = ch_valid[i] && !ch_done[i] && (word_cnt[i] != len_q);
        end
        if (state == StSave) begin
            for (int j = 0; j < NCH; j++) begin
                if (!gnt_found && eligible[idx]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = idx;
                end
                idx = (32'(idx) == NCH - 1) ? '0 : idx + 1'b1;
            end
            if (gnt_found) begin
                ch_ready[gnt_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        done_d = ch_done;
        for (int i = 0; i < NCH; i++) begin
            if (word_cnt[i] == len_q) begin
                done_d[i] = 1'b1;
            end else if (ch_ready[i] && ch_valid[i] && (word_cnt[i] + AW'(1) == len_q)) begin
                done_d[i] = 1'b1;
            end
        end
    end

    assign rd_issue     = user_rd_en && (state != StSave);
    assign user_rd_data = user_rd_valid ? bram_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            len_q         <= '0;
            rr_ptr        <= '0;
            rd_pend       <= 1'b0;
            user_rd_valid <= 1'b0;
            bram_en       <= 1'b0;
            bram_we       <= 1'b0;
            bram_addr     <= '0;
            bram_wdata    <= '0;
            ch_done       <= '0;
            all_done      <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                addr_cnt[i] <= '0;
                word_cnt[i] <= '0;
            end
        end else begin
            bram_en       <= 1'b0;
            bram_we       <= 1'b0;
            rd_pend       <= 1'b0;
            user_rd_valid <= rd_pend;

            if (rd_issue) begin
                bram_en   <= 1'b1;
                bram_addr <= user_addr;
                rd_pend   <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (saving_mode) begin
                        state   <= StSave;
                        len_q   <= ch_len;
                        ch_done <= '0;
                        for (int i = 0; i < NCH; i++) begin
                            addr_cnt[i] <= starting_addr[i*AW +: AW];
                            word_cnt[i] <= '0;
                        end
                    end
                end
                StSave: begin
                    if (gnt_found) begin
                        bram_en           <= 1'b1;
                        bram_we           <= 1'b1;
                        bram_addr         <= addr_cnt[gnt_idx];
                        bram_wdata        <= ch_data[gnt_idx*DW +: DW];
                        addr_cnt[gnt_idx] <= addr_cnt[gnt_idx] + AW'(1);
                        word_cnt[gnt_idx] <= word_cnt[gnt_idx] + AW'(1);
                        rr_ptr            <= (32'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
                    end
                    ch_done <= done_d;
                    if (!saving_mode) begin
                        state <= StIdle;
                    end else if (&done_d) begin
                        state    <= StDone;
                        all_done <= 1'b1;
                    end
                end
                StDone: begin
                    if (!saving_mode) begin
                        state    <= StIdle;
                        all_done <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_save_scheduler.sv
// Directed bench for bram_save_scheduler with a behavioural BRAM and a write/grant monitor.
module tb_bram_save_scheduler;

    localparam int NCH = 8;
    localparam int AW  = 18;
    localparam int DW  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              saving_mode;
    logic [NCH*AW-1:0] starting_addr;
    logic [AW-1:0]     ch_len;
    logic [NCH-1:0]    ch_valid;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_ready;
    logic              user_rd_en;
    logic [AW-1:0]     user_addr;
    logic              user_rd_valid;
    logic [DW-1:0]     user_rd_data;
    logic              bram_en;
    logic              bram_we;
    logic [AW-1:0]     bram_addr;
    logic [DW-1:0]     bram_wdata;
    logic [DW-1:0]     bram_rdata = '0;
    logic [NCH-1:0]    ch_done;
    logic              all_done;

    int n_checks = 0;
    int n_fail   = 0;

    bram_save_scheduler #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .saving_mode   (saving_mode),
        .starting_addr (starting_addr),
        .ch_len        (ch_len),
        .ch_valid      (ch_valid),
        .ch_data       (ch_data),
        .ch_ready      (ch_ready),
        .user_rd_en    (user_rd_en),
        .user_addr     (user_addr),
        .user_rd_valid (user_rd_valid),
        .user_rd_data  (user_rd_data),
        .bram_en       (bram_en),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_wdata    (bram_wdata),
        .bram_rdata    (bram_rdata),
        .ch_done       (ch_done),
        .all_done      (all_done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_wdata;
            else         bram_rdata     <= mem[bram_addr];
        end
    end

    // Channel i presents word {i, k} for its k-th word of the pass.
    logic [NCH-1:0] xfer_mask = '0;
    logic [7:0]     sent [NCH];
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NCH; i++) begin
            if (!rst_n)            sent[i] <= '0;
            else if (xfer_mask[i]) sent[i] <= sent[i] + 8'd1;
        end
    end
    always_comb begin
        ch_data = '0;
        for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = {3'(i), sent[i][4:0]};
    end

    int            cyc = 0;
    int            gnt_q [$];
    int            gnt_cyc [$];
    int            wc_q [$];
    logic [AW-1:0] wa_q [$];
    logic [DW-1:0] wd_q [$];
    int            nreads = 0;
    int            nvalid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        xfer_mask <= ch_valid & ch_ready;
        for (int i = 0; i < NCH; i++) begin
            if (ch_valid[i] && ch_ready[i]) begin
                gnt_q.push_back(i);
                gnt_cyc.push_back(cyc);
            end
        end
        if (bram_en && bram_we) begin
            wa_q.push_back(bram_addr);
            wd_q.push_back(bram_wdata);
            wc_q.push_back(cyc);
        end
        if (bram_en && !bram_we) nreads <= nreads + 1;
        if (user_rd_valid)       nvalid <= nvalid + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        saving_mode = 1'b0;
        user_rd_en  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic set_base_addrs();
        for (int i = 0; i < NCH; i++) starting_addr[i*AW +: AW] = AW'(i * 1000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; saving_mode = 1'b0; user_rd_en = 1'b0; user_addr = '0;
        ch_valid = '0; ch_len = '0; starting_addr = '0;
        #3;
        n_checks++; if (bram_en !== 1'b0) begin n_fail++; $display("FAIL reset_bram_en got %b want 0", bram_en); end
        n_checks++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL reset_bram_we got %b want 0", bram_we); end
        n_checks++; if (bram_addr !== '0) begin n_fail++; $display("FAIL reset_bram_addr got %0d want 0", bram_addr); end
        n_checks++; if (bram_wdata !== '0) begin n_fail++; $display("FAIL reset_bram_wdata got %h want 0", bram_wdata); end
        n_checks++; if (ch_done !== '0 || all_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done got %h/%b want 00/0", ch_done, all_done); end
        n_checks++; if (user_rd_valid !== 1'b0 || user_rd_data !== '0) begin
            n_fail++; $display("FAIL reset_user got %b/%h want 0/00", user_rd_valid, user_rd_data); end
        n_checks++; if (ch_ready !== '0) begin n_fail++; $display("FAIL reset_ch_ready got %h want 00", ch_ready); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        int gs, ws, bad;
        set_base_addrs();
        ch_len = AW'(32); ch_valid = '1;
        gs = gnt_q.size(); ws = wa_q.size();
        saving_mode = 1'b1;
        for (int t = 0; t < 400 && !all_done; t++) step();
        n_checks++; if (all_done !== 1'b1) begin n_fail++; $display("FAIL rr_all_done_timeout got %b want 1", all_done); end
        step();
        n_checks++; if (wa_q.size() - ws != 256) begin
            n_fail++; $display("FAIL rr_write_count got %0d want 256", wa_q.size() - ws); end
        bad = 0;
        for (int j = 0; j < 256 && gs + j < gnt_q.size(); j++) if (gnt_q[gs+j] != j % 8) bad++;
        n_checks++; if (bad != 0 || gnt_q.size() - gs != 256) begin
            n_fail++; $display("FAIL rr_grant_order got %0d bad of %0d want 0 of 256", bad, gnt_q.size() - gs); end
        bad = 0;
        for (int j = 0; j < 256 && ws + j < wa_q.size(); j++) begin
            if (wa_q[ws+j] != AW'((j % 8) * 1000 + j / 8)) bad++;
            if (wd_q[ws+j] != {3'(j % 8), 5'(j / 8)}) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rr_write_addr_data got %0d bad want 0", bad); end
        if (wc_q.size() >= ws + 256 && gnt_cyc.size() >= gs + 256) begin
            n_checks++; if (wc_q[ws+255] - wc_q[ws] != 255 || wc_q[ws] != gnt_cyc[gs] + 1) begin
                n_fail++; $display("FAIL rr_write_timing got span %0d lat %0d want 255 1",
                                   wc_q[ws+255] - wc_q[ws], wc_q[ws] - gnt_cyc[gs]); end
        end
        n_checks++; if (ch_done !== 8'hFF || ch_ready !== '0) begin
            n_fail++; $display("FAIL rr_done_state got %h/%h want ff/00", ch_done, ch_ready); end
    endtask

    task automatic test_user_read();
        step(); saving_mode = 1'b0;
        step(); user_rd_en = 1'b1; user_addr = AW'(3005);
        step();
        n_checks++; if (bram_en !== 1'b1 || bram_we !== 1'b0 || bram_addr !== AW'(3005)) begin
            n_fail++; $display("FAIL rd_issue got en%b we%b a%0d want en1 we0 a3005", bram_en, bram_we, bram_addr); end
        n_checks++; if (user_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_early_valid got %b want 0", user_rd_valid); end
        user_addr = AW'(3006);
        step();
        n_checks++; if (user_rd_valid !== 1'b1 || user_rd_data !== 8'h65) begin
            n_fail++; $display("FAIL rd_first got %b/%h want 1/65", user_rd_valid, user_rd_data); end
        user_rd_en = 1'b0;
        step();
        n_checks++; if (user_rd_valid !== 1'b1 || user_rd_data !== 8'h66) begin
            n_fail++; $display("FAIL rd_back_to_back got %b/%h want 1/66", user_rd_valid, user_rd_data); end
        step();
        n_checks++; if (user_rd_valid !== 1'b0 || bram_en !== 1'b0) begin
            n_fail++; $display("FAIL rd_idle got %b/%b want 0/0", user_rd_valid, bram_en); end
    endtask

    task automatic test_two_channels();
        int gs, rs, vs;
        do_reset();
        set_base_addrs();
        ch_len = AW'(2); ch_valid = 8'b0010_0100;
        gs = gnt_q.size();
        step(); saving_mode = 1'b1;
        step(); user_rd_en = 1'b1; user_addr = AW'(5);
        rs = nreads; vs = nvalid;
        for (int t = 0; t < 20; t++) step();
        n_checks++; if (gnt_q.size() - gs != 4) begin
            n_fail++; $display("FAIL two_grant_count got %0d want 4", gnt_q.size() - gs); end
        else begin
            n_checks++; if (gnt_q[gs] != 2 || gnt_q[gs+1] != 5 || gnt_q[gs+2] != 2 || gnt_q[gs+3] != 5) begin
                n_fail++; $display("FAIL two_grant_order got %0d %0d %0d %0d want 2 5 2 5",
                                   gnt_q[gs], gnt_q[gs+1], gnt_q[gs+2], gnt_q[gs+3]); end
        end
        n_checks++; if (ch_done !== 8'b0010_0100 || all_done !== 1'b0) begin
            n_fail++; $display("FAIL two_done got %h/%b want 24/0", ch_done, all_done); end
        n_checks++; if (nreads != rs || nvalid != vs) begin
            n_fail++; $display("FAIL save_read_ignored got reads %0d valids %0d want 0 0", nreads - rs, nvalid - vs); end
        saving_mode = 1'b0; user_rd_en = 1'b0;
        step(); step();
        n_checks++; if (ch_done !== 8'b0010_0100) begin
            n_fail++; $display("FAIL abort_hold got %h want 24", ch_done); end
    endtask

    task automatic test_len_zero();
        int ws;
        do_reset();
        set_base_addrs();
        ch_len = '0; ch_valid = '1;
        ws = wa_q.size();
        step(); saving_mode = 1'b1;
        step();
        n_checks++; if (ch_ready !== '0 || ch_done !== '0) begin
            n_fail++; $display("FAIL len0_cycle1 got %h/%h want 00/00", ch_ready, ch_done); end
        step();
        n_checks++; if (ch_done !== 8'hFF || all_done !== 1'b1) begin
            n_fail++; $display("FAIL len0_cycle2 got %h/%b want ff/1", ch_done, all_done); end
        step(); step(); step();
        n_checks++; if (wa_q.size() != ws) begin
            n_fail++; $display("FAIL len0_writes got %0d want 0", wa_q.size() - ws); end
        saving_mode = 1'b0;
        step();
    endtask

    task automatic test_addr_wrap();
        int ws;
        do_reset();
        set_base_addrs();
        starting_addr[0 +: AW] = AW'((1 << AW) - 2);
        ch_len = AW'(4); ch_valid = 8'b0000_0001;
        ws = wa_q.size();
        step(); saving_mode = 1'b1;
        for (int t = 0; t < 30 && !ch_done[0]; t++) step();
        step();
        n_checks++; if (wa_q.size() - ws != 4 || ch_done !== 8'h01) begin
            n_fail++; $display("FAIL wrap_count got %0d/%h want 4/01", wa_q.size() - ws, ch_done); end
        else begin
            n_checks++; if (wa_q[ws] != AW'(262142) || wa_q[ws+1] != AW'(262143) ||
                            wa_q[ws+2] != AW'(0) || wa_q[ws+3] != AW'(1)) begin
                n_fail++; $display("FAIL wrap_addrs got %0d %0d %0d %0d want 262142 262143 0 1",
                                   wa_q[ws], wa_q[ws+1], wa_q[ws+2], wa_q[ws+3]); end
        end
        saving_mode = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_save();
        int ws, bad;
        do_reset();
        set_base_addrs();
        ch_len = AW'(32); ch_valid = '1;
        ws = wa_q.size();
        step(); saving_mode = 1'b1;
        for (int t = 0; t < 50 && wa_q.size() - ws < 10; t++) step();
        n_checks++; if (wa_q.size() - ws < 10) begin
            n_fail++; $display("FAIL mid_timeout got %0d writes want 10", wa_q.size() - ws); end
        @(negedge clk);
        #2;
        rst_n = 1'b0; saving_mode = 1'b0;
        #1;
        n_checks++; if (bram_en !== 1'b0 || bram_we !== 1'b0 || bram_addr !== '0 || bram_wdata !== '0) begin
            n_fail++; $display("FAIL mid_reset_bram got en%b we%b a%0d d%h want all 0",
                               bram_en, bram_we, bram_addr, bram_wdata); end
        n_checks++; if (ch_ready !== '0 || ch_done !== '0 || all_done !== 1'b0 || user_rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_ctrl got %h/%h/%b/%b want all 0",
                               ch_ready, ch_done, all_done, user_rd_valid); end
        step(); step();
        rst_n = 1'b1;
        ws = wa_q.size();
        step(); step(); step();
        n_checks++; if (wa_q.size() != ws) begin
            n_fail++; $display("FAIL mid_idle_wait got %0d writes want 0", wa_q.size() - ws); end
        saving_mode = 1'b1;
        for (int t = 0; t < 12; t++) step();
        bad = 0;
        for (int j = 0; j < 8 && ws + j < wa_q.size(); j++) begin
            if (wa_q[ws+j] != AW'(j * 1000) || wd_q[ws+j] != {3'(j), 5'd0}) bad++;
        end
        n_checks++; if (bad != 0 || wa_q.size() - ws < 8) begin
            n_fail++; $display("FAIL mid_restart got %0d bad of %0d want 0 of 8", bad, wa_q.size() - ws); end
        saving_mode = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_user_read();
        test_two_channels();
        test_len_zero();
        test_addr_wrap();
        test_reset_mid_save();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
